// File: rtl/rsa_dma_pkg.sv
// Shared types and sizing for the RSA accelerator DMA engine.
package rsa_dma_pkg;

    localparam int unsigned DATA_W          = 1024;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned WORDS           = DATA_W / WORD_W;
    localparam int unsigned IDX_W           = $clog2(WORDS);
    localparam int unsigned TIMEOUT_DEFAULT = 1024;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } dma_state_t;

endpackage

// File: rtl/rsa_dma_word_buf.sv
// 1024-bit block buffer: whole-block load (tx snapshot) plus indexed word
// read/write (tx word fetch, rx shadow fill).
module rsa_dma_word_buf
    import rsa_dma_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [WORD_W-1:0] i_wr_data,
    output logic [WORD_W-1:0] o_rd_data,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_buf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf <= '0;
        end else if (i_load) begin
            r_buf <= i_load_data;
        end else if (i_wr_en) begin
            r_buf[i_idx * WORD_W +: WORD_W] <= i_wr_data;
        end
    end

    assign o_rd_data = r_buf[i_idx * WORD_W +: WORD_W];
    assign o_data    = r_buf;

endmodule

// File: rtl/rsa_dma_engine.sv
// Responder-side DMA engine: moves one 1024-bit block between the RSA
// accelerator and memory as 32 little-endian 32-bit words over req/ack.
module rsa_dma_engine
    import rsa_dma_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dma_rx_start,
    input  logic [31:0]       dma_rx_address,
    input  logic              dma_tx_start,
    input  logic [31:0]       dma_tx_address,
    input  logic [DATA_W-1:0] dma_tx_data,
    output logic [DATA_W-1:0] dma_rx_data,
    output logic              dma_done,
    output logic              dma_idle,
    output logic              dma_error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_err
);

    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

    dma_state_t        r_state;
    dma_state_t        w_next;
    logic [31:0]       r_base;
    logic [IDX_W-1:0]  r_idx;
    logic [TCNT_W-1:0] r_tcnt;
    logic              r_we;
    logic              r_misalign;
    logic              r_error;
    logic [DATA_W-1:0] r_rx_data;

    logic              w_start;
    logic              w_accept;
    logic [31:0]       w_start_addr;
    logic              w_req;
    logic              w_last;
    logic              w_timeout;
    logic [WORD_W-1:0] w_buf_word;
    logic [DATA_W-1:0] w_buf_data;

    assign w_start      = dma_rx_start | dma_tx_start;
    assign w_accept     = (r_state == IDLE) && w_start;
    assign w_start_addr = dma_rx_start ? dma_rx_address : dma_tx_address;
    assign w_last       = (r_idx == IDX_W'(WORDS - 1));
    assign w_timeout    = w_req && !mem_ack && (r_tcnt == TCNT_W'(TIMEOUT - 1));

    rsa_dma_word_buf u_buf (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_accept),
        .i_load_data (dma_tx_data),
        .i_wr_en     (w_req && mem_ack && !mem_err && !r_we),
        .i_idx       (r_idx),
        .i_wr_data   (mem_rdata),
        .o_rd_data   (w_buf_word),
        .o_data      (w_buf_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A misaligned start spends one request-free XFER cycle before DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_start) w_next = XFER;
            XFER: begin
                if (r_misalign) begin
                    w_next = DONE;
                end else if (mem_ack && (mem_err || w_last)) begin
                    w_next = DONE;
                end else if (w_timeout) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        dma_idle = 1'b0;
        dma_done = 1'b0;
        w_req    = 1'b0;
        case (r_state)
            IDLE:    dma_idle = 1'b1;
            XFER:    w_req    = !r_misalign;
            DONE:    dma_done = 1'b1;
            default: dma_idle = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_base     <= '0;
            r_idx      <= '0;
            r_tcnt     <= '0;
            r_we       <= 1'b0;
            r_misalign <= 1'b0;
            r_error    <= 1'b0;
            r_rx_data  <= '0;
        end else if (w_accept) begin
            r_base     <= w_start_addr;
            r_idx      <= '0;
            r_tcnt     <= '0;
            r_we       <= !dma_rx_start;
            r_misalign <= (w_start_addr[1:0] != 2'b00);
            r_error    <= 1'b0;
        end else if (r_state == XFER) begin
            if (r_misalign) begin
                r_error <= 1'b1;
            end else if (mem_ack) begin
                r_tcnt <= '0;
                if (mem_err) begin
                    r_error <= 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                    // The final word is still in flight, so splice it in here.
                    if (!r_we && w_last) begin
                        r_rx_data                    <= w_buf_data;
                        r_rx_data[DATA_W-1 -: WORD_W] <= mem_rdata;
                    end
                end
            end else if (w_timeout) begin
                r_error <= 1'b1;
            end else begin
                r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end

    assign mem_req     = w_req;
    assign mem_we      = r_we;
    assign mem_addr    = r_base + {{(32 - IDX_W - 2){1'b0}}, r_idx, 2'b00};
    assign mem_wdata   = w_buf_word;
    assign dma_error   = r_error;
    assign dma_rx_data = r_rx_data;

endmodule

// File: tb/tb_rsa_dma_engine.sv
// Directed bench for rsa_dma_engine with a behavioural memory responder.
module tb_rsa_dma_engine;
    import rsa_dma_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              dma_rx_start, dma_tx_start;
    logic [31:0]       dma_rx_address, dma_tx_address;
    logic [DATA_W-1:0] dma_tx_data;
    logic [DATA_W-1:0] dma_rx_data;
    logic              dma_done, dma_idle, dma_error;
    logic              mem_req, mem_we;
    logic [31:0]       mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ack   = 1'b0;
    logic [WORD_W-1:0] mem_rdata = '0;
    logic              mem_err   = 1'b0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    rsa_dma_engine #(.TIMEOUT(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .dma_rx_start   (dma_rx_start),
        .dma_rx_address (dma_rx_address),
        .dma_tx_start   (dma_tx_start),
        .dma_tx_address (dma_tx_address),
        .dma_tx_data    (dma_tx_data),
        .dma_rx_data    (dma_rx_data),
        .dma_done       (dma_done),
        .dma_idle       (dma_idle),
        .dma_error      (dma_error),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .mem_err        (mem_err)
    );

    always #5 clk = ~clk;

    // Memory responder: decides ack for the coming edge at each falling edge.
    // ack_mode 0 = ack every request cycle, 1 = random 0-5 cycle delay, 2 = never.
    int          ack_mode   = 0;
    int          err_word   = -1;
    logic [31:0] cur_base   = '0;
    logic [31:0] rd_xor     = '0;
    logic [31:0] resp_idx   = '0;
    logic [31:0] wr_mem [WORDS];
    int unsigned ack_cnt    = 0;
    int unsigned delay_left = 0;

    always @(negedge clk) begin
        mem_ack = 1'b0;
        mem_err = 1'b0;
        if (!mem_req) begin
            delay_left = $urandom_range(0, 5);
        end else if (ack_mode != 2) begin
            if (ack_mode == 1 && delay_left != 0) begin
                delay_left--;
            end else begin
                resp_idx  = (mem_addr - cur_base) >> 2;
                mem_ack   = 1'b1;
                mem_rdata = (32'hA000_0000 + resp_idx) ^ rd_xor;
                mem_err   = (int'(resp_idx) == err_word);
                if (mem_we) wr_mem[resp_idx[4:0]] = mem_wdata;
                ack_cnt++;
                delay_left = $urandom_range(0, 5);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input logic rx, input logic tx, input logic [31:0] ra, input logic [31:0] ta);
        dma_rx_start   = rx;
        dma_tx_start   = tx;
        dma_rx_address = ra;
        dma_tx_address = ta;
        @(posedge clk);
        #1;
        dma_rx_start = 1'b0;
        dma_tx_start = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] exp_rx, tx_pat, snap;
        logic [31:0]       prev_addr, prev_wdata;
        logic              prev_pend, err_snap;
        int                done_cyc, done_cnt, addr_ok, req_cyc;
        int unsigned       n0;

        reset          = 1'b1;
        dma_rx_start   = 1'b0;
        dma_tx_start   = 1'b0;
        dma_rx_address = '0;
        dma_tx_address = '0;
        dma_tx_data    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("rst_idle", 32'(dma_idle), 1);
        chk("rst_done", 32'(dma_done), 0);
        chk("rst_error", 32'(dma_error), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk_blk("rst_rx_data", dma_rx_data, '0);

        // rx at 0x1000, ack every cycle
        cur_base = 32'h1000;
        ack_mode = 0;
        for (int i = 0; i < 32; i++) exp_rx[i*32 +: 32] = 32'hA000_0000 + i;
        start(1'b1, 1'b0, 32'h1000, 32'h0);
        done_cyc = 0; done_cnt = 0; addr_ok = 0; snap = '0; err_snap = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            tick();
            if (c == 1) chk("rx1_idle_low", 32'(dma_idle), 0);
            if (c <= 32 && mem_req && mem_addr === 32'h1000 + 4 * (c - 1)) addr_ok++;
            if (dma_done) begin
                done_cnt++;
                done_cyc = c;
                snap     = dma_rx_data;
                err_snap = dma_error;
            end
        end
        chk("rx1_addr_seq", addr_ok, 32);
        chk("rx1_done_cycle", done_cyc, 33);
        chk("rx1_done_count", done_cnt, 1);
        chk("rx1_word0", snap[31:0], 32'hA000_0000);
        chk("rx1_word31", snap[1023:992], 32'hA000_001F);
        chk_blk("rx1_block", snap, exp_rx);
        chk("rx1_error", 32'(err_snap), 0);
        chk("rx1_idle_after", 32'(dma_idle), 1);

        // tx at 0x2000, source changes after start, random ack delays
        for (int i = 0; i < 32; i++) tx_pat[i*32 +: 32] = 32'h1234_0000 + i * 32'h0001_0003;
        dma_tx_data = tx_pat;
        cur_base    = 32'h2000;
        ack_mode    = 1;
        start(1'b0, 1'b1, 32'h0, 32'h2000);
        dma_tx_data = ~tx_pat;
        prev_pend = 1'b0; prev_addr = '0; prev_wdata = '0; done_cyc = 0;
        for (int c = 1; c <= 400 && done_cyc == 0; c++) begin
            tick();
            if (c == 1) chk("tx_we", 32'(mem_we), 1);
            if (prev_pend && mem_req) begin
                chk("tx_addr_stable", mem_addr, prev_addr);
                chk("tx_wdata_stable", mem_wdata, prev_wdata);
            end
            prev_pend  = mem_req && !mem_ack;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
            if (dma_done) done_cyc = c;
        end
        chk("tx_done_seen", 32'(done_cyc != 0), 1);
        chk("tx_error", 32'(dma_error), 0);
        for (int i = 0; i < 32; i++) chk($sformatf("tx_mem_word%0d", i), wr_mem[i], tx_pat[i*32 +: 32]);

        // misaligned rx: no requests, done in cycle 2, rx data untouched
        ack_mode = 0;
        tick();
        start(1'b1, 1'b0, 32'h1002, 32'h0);
        tick();
        chk("mis_c1_req", 32'(mem_req), 0);
        chk("mis_c1_done", 32'(dma_done), 0);
        chk("mis_c1_idle", 32'(dma_idle), 0);
        tick();
        chk("mis_c2_done", 32'(dma_done), 1);
        chk("mis_c2_error", 32'(dma_error), 1);
        chk("mis_c2_req", 32'(mem_req), 0);
        chk_blk("mis_rx_kept", dma_rx_data, exp_rx);
        tick();
        chk("mis_c3_idle", 32'(dma_idle), 1);
        chk("mis_error_sticky", 32'(dma_error), 1);

        // valid rx clears the error and loads a new block
        rd_xor   = 32'h00FF_0000;
        cur_base = 32'h1400;
        start(1'b1, 1'b0, 32'h1400, 32'h0);
        tick();
        chk("rx2_error_cleared", 32'(dma_error), 0);
        done_cyc = 0;
        for (int c = 2; c <= 60 && done_cyc == 0; c++) begin
            tick();
            if (dma_done) done_cyc = c;
        end
        for (int i = 0; i < 32; i++) exp_rx[i*32 +: 32] = (32'hA000_0000 + i) ^ 32'h00FF_0000;
        chk("rx2_done_cycle", done_cyc, 33);
        chk_blk("rx2_block", dma_rx_data, exp_rx);

        // bus error on word 5
        rd_xor   = 32'h0F0F_0000;
        err_word = 5;
        cur_base = 32'h3000;
        n0       = ack_cnt;
        tick();
        start(1'b1, 1'b0, 32'h3000, 32'h0);
        done_cyc = 0;
        for (int c = 1; c <= 60 && done_cyc == 0; c++) begin
            tick();
            if (dma_done) done_cyc = c;
        end
        chk("err_done_cycle", done_cyc, 7);
        chk("err_req_count", ack_cnt - n0, 6);
        chk("err_error", 32'(dma_error), 1);
        chk_blk("err_rx_kept", dma_rx_data, exp_rx);
        tick();
        chk("err_req_after", 32'(mem_req), 0);
        chk("err_idle_after", 32'(dma_idle), 1);
        chk("err_req_count_after", ack_cnt - n0, 6);
        err_word = -1;

        // timeout with no ack (TIMEOUT=16)
        ack_mode = 2;
        cur_base = 32'h4000;
        tick();
        start(1'b1, 1'b0, 32'h4000, 32'h0);
        done_cyc = 0; req_cyc = 0;
        for (int c = 1; c <= 60 && done_cyc == 0; c++) begin
            tick();
            if (mem_req) req_cyc++;
            if (dma_done) done_cyc = c;
        end
        chk("to_req_cycles", req_cyc, 16);
        chk("to_done_cycle", done_cyc, 17);
        chk("to_error", 32'(dma_error), 1);
        tick();
        chk("to_idle_after", 32'(dma_idle), 1);

        // both starts together, then reset at word 10
        ack_mode = 0;
        cur_base = 32'h5000;
        tick();
        start(1'b1, 1'b1, 32'h5000, 32'h6000);
        tick();
        chk("both_we_rx", 32'(mem_we), 0);
        chk("both_addr", mem_addr, 32'h5000);
        for (int c = 2; c <= 11; c++) tick();
        chk("both_word10_addr", mem_addr, 32'h5028);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst2_req", 32'(mem_req), 0);
        chk("rst2_idle", 32'(dma_idle), 1);
        chk("rst2_done", 32'(dma_done), 0);
        chk_blk("rst2_rx_data", dma_rx_data, '0);
        done_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (dma_done) done_cnt++;
        end
        chk("rst2_no_done", done_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
